// File: rtl/dual_channel_sync_fifo.sv
// ============================================================================
//  Module   : dual_channel_sync_fifo
//  Brief    : Synchronous FIFO fed from one of two input channels through a
//             2:1 selector. Read data is registered (1-cycle latency) and
//             qualified by Data_Valid. Full/Empty are decoded from the
//             registered occupancy count only.
//  Options  : define FIFO_ERR_FLAGS_EN to add sticky Overflow/Underflow
//             outputs flagging requests dropped while Full/Empty.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_channel_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mux,
  input  logic                  Write,
  input  logic                  Read,
  input  logic [DATA_WIDTH-1:0] Ch1_Data,
  input  logic [DATA_WIDTH-1:0] Ch2_Data,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Level
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  Overflow,
  output logic                  Underflow
`endif
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q,  level_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  valid_q,  valid_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] wr_data;

  // Flags come from the registered level only, never from same-cycle requests.
  assign Full  = (level_q == DEPTH_LVL);
  assign Empty = (level_q == '0);

  assign wr_acc  = Write & ~Full;
  assign rd_acc  = Read  & ~Empty;
  assign wr_data = Mux ? Ch1_Data : Ch2_Data;

  assign Data_Out   = dout_q;
  assign Data_Valid = valid_q;
  assign Level      = level_q;

  // Next-state: pointer advance, occupancy update and registered read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    valid_d  = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array: written only on accepted writes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: a request seen while Full/Empty is one that was dropped.
  always_comb begin
    ovf_d = ovf_q | (Write & Full);
    udf_d = udf_q | (Read  & Empty);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_channel_sync_fifo.sv
// ============================================================================
//  Module   : tb_dual_channel_sync_fifo
//  Brief    : Directed self-checking bench for dual_channel_sync_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_channel_sync_fifo;

  logic       clk;
  logic       reset;
  logic       Mux;
  logic       Write;
  logic       Read;
  logic [7:0] Ch1_Data;
  logic [7:0] Ch2_Data;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic       Full;
  logic       Empty;
  logic [4:0] Level;
`ifdef FIFO_ERR_FLAGS_EN
  logic       Overflow;
  logic       Underflow;
`endif

  int errors = 0;
  int checks = 0;

  dual_channel_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Mux        (Mux),
    .Write      (Write),
    .Read       (Read),
    .Ch1_Data   (Ch1_Data),
    .Ch2_Data   (Ch2_Data),
    .Data_Out   (Data_Out),
    .Data_Valid (Data_Valid),
    .Full       (Full),
    .Empty      (Empty),
    .Level      (Level)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .Overflow   (Overflow),
    .Underflow  (Underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic w, input logic r, input logic m,
                        input logic [7:0] c1, input logic [7:0] c2);
    Write    = w;
    Read     = r;
    Mux      = m;
    Ch1_Data = c1;
    Ch2_Data = c2;
  endtask

  initial begin
    set_in(0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    step();
    step();
    // ---------------- reset state
    chk("rst_level", 32'(Level), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_full",  32'(Full), 0);
    chk("rst_valid", 32'(Data_Valid), 0);
    chk("rst_dout",  32'(Data_Out), 0);
    reset = 1'b1;
    step();

    // ---------------- fill from channel 1
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 1, 8'(i), 8'(8'hF0 | i));
      step();
      if (i == 0) begin
        chk("fill1_level", 32'(Level), 1);
        chk("fill1_empty", 32'(Empty), 0);
      end
      if (i == 14) chk("fill15_full", 32'(Full), 0);
    end
    chk("fill_full",  32'(Full), 1);
    chk("fill_level", 32'(Level), 16);
    chk("fill_empty", 32'(Empty), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_clear", 32'(Overflow), 0);
`endif
    set_in(1, 0, 1, 8'hAA, 8'h55);
    step();
    chk("wr17_level", 32'(Level), 16);
    chk("wr17_full",  32'(Full), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(Overflow), 1);
`endif

    // ---------------- drain 17 reads
    set_in(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_valid", 32'(Data_Valid), 1);
      chk("drain_data",  32'(Data_Out), 32'(i));
    end
    chk("drain_empty", 32'(Empty), 1);
    chk("drain_level", 32'(Level), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_clear", 32'(Underflow), 0);
`endif
    step();
    chk("rd17_valid", 32'(Data_Valid), 0);
    chk("rd17_dout",  32'(Data_Out), 8'h0F);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_set", 32'(Underflow), 1);
`endif

    // ---------------- channel select
    set_in(1, 0, 1, 8'h11, 8'hEE); step();
    set_in(1, 0, 0, 8'hDD, 8'h22); step();
    set_in(1, 0, 1, 8'h33, 8'hCC); step();
    chk("sel_level", 32'(Level), 3);
    set_in(0, 1, 0, 8'h00, 8'h00);
    step(); chk("sel_rd0", 32'(Data_Out), 8'h11);
    step(); chk("sel_rd1", 32'(Data_Out), 8'h22);
    step(); chk("sel_rd2", 32'(Data_Out), 8'h33);
    set_in(0, 0, 0, 8'h00, 8'h00);
    step();
    chk("hold_valid", 32'(Data_Valid), 0);
    chk("hold_dout",  32'(Data_Out), 8'h33);

    // ---------------- simultaneous at level 5
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 8'h00, 8'(8'h50 + i));
      step();
    end
    chk("sim5_pre_level", 32'(Level), 5);
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 8'h00, 8'(8'h55 + i));
      step();
      chk("sim5_level", 32'(Level), 5);
      chk("sim5_valid", 32'(Data_Valid), 1);
      chk("sim5_data",  32'(Data_Out), 32'(8'h50 + i));
    end
    set_in(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sim5_tail", 32'(Data_Out), 32'(8'h5A + i));
    end
    chk("sim5_empty", 32'(Empty), 1);

    // ---------------- simultaneous at level 16
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 1, 8'(8'h60 + i), 8'h00);
      step();
    end
    chk("sim16_full", 32'(Full), 1);
    set_in(1, 1, 1, 8'h77, 8'h00);
    step();
    chk("sim16_level", 32'(Level), 15);
    chk("sim16_valid", 32'(Data_Valid), 1);
    chk("sim16_data",  32'(Data_Out), 8'h60);
    set_in(0, 1, 0, 8'h00, 8'h00);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("sim16_tail", 32'(Data_Out), 32'(8'h60 + i));
    end
    chk("sim16_empty", 32'(Empty), 1);

    // ---------------- simultaneous at level 0
    set_in(1, 1, 1, 8'h88, 8'h00);
    step();
    chk("sim0_level", 32'(Level), 1);
    chk("sim0_valid", 32'(Data_Valid), 0);
    chk("sim0_dout",  32'(Data_Out), 8'h6F);
    set_in(0, 1, 0, 8'h00, 8'h00);
    step();
    chk("sim0_rd", 32'(Data_Out), 8'h88);
    chk("sim0_rd_valid", 32'(Data_Valid), 1);

    // ---------------- wrap-around
    for (int i = 0; i < 12; i++) begin
      set_in(1, 0, 1, 8'(8'h30 + i), 8'h00);
      step();
    end
    set_in(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("wrap_pre", 32'(Data_Out), 32'(8'h30 + i));
    end
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0, 8'h00, 8'(8'h40 + i));
      step();
    end
    chk("wrap_full", 32'(Full), 1);
    set_in(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("wrap_data", 32'(Data_Out), 32'(8'h40 + i));
    end
    chk("wrap_empty", 32'(Empty), 1);

    // ---------------- asynchronous reset mid-operation
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 1, 8'(8'h90 + i), 8'h00);
      step();
    end
    set_in(0, 1, 0, 8'h00, 8'h00);
    step();
    chk("pre_rst_level", 32'(Level), 7);
    chk("pre_rst_valid", 32'(Data_Valid), 1);
    set_in(0, 0, 0, 8'h00, 8'h00);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_level", 32'(Level), 0);
    chk("arst_empty", 32'(Empty), 1);
    chk("arst_full",  32'(Full), 0);
    chk("arst_valid", 32'(Data_Valid), 0);
    chk("arst_dout",  32'(Data_Out), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("arst_ovf", 32'(Overflow), 0);
    chk("arst_udf", 32'(Underflow), 0);
`endif
    step();
    reset = 1'b1;
    step();
    chk("post_rst_empty", 32'(Empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
